// File: rtl/traffic_pkg.sv
// Shared types and constants for the N-approach traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} state_t;

  // Lamp-plane indices into the packed lamp array.
  localparam int G = 0;
  localparam int Y = 1;
  localparam int R = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_tick.sv
// Clock prescaler: one-cycle tick every TICK_DIV cycles, restartable from 0.
module traffic_tick #(
  parameter int TICK_DIV = 100000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_restart) r_cnt <= '0;
    else if (o_tick)        r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/traffic_ctrl.sv
// Round-robin N-approach traffic-light controller with rest-on-green and
// maintenance flash; lamps are registered from the next-state decode.
module traffic_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int TICK_DIV = 100000000,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_DIR-1:0]         i_req,
  input  logic                     i_flash,
  output logic [N_DIR-1:0]         o_green,
  output logic [N_DIR-1:0]         o_yellow,
  output logic [N_DIR-1:0]         o_red,
  output logic [$clog2(N_DIR)-1:0] o_active
);

  localparam int AW = $clog2(N_DIR);
  localparam int TW = $clog2(max3(GREEN_T, YELLOW_T, ALLRED_T) + 1);

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic [AW-1:0]     r_active, w_active_nxt;
  logic              r_phase, w_phase_nxt;
  logic              w_restart, w_tick, w_expire, w_other;
  logic [2:0][N_DIR-1:0] w_lamp;
  logic [N_DIR-1:0]  r_green, r_yellow, r_red;

  // Priority scan starting just after cur; a lone request on cur is found last.
  function automatic logic [AW-1:0] f_next_req(input logic [AW-1:0] cur,
                                               input logic [N_DIR-1:0] rq);
    int   idx;
    logic found;
    f_next_req = AW'((int'(cur) + 1) % N_DIR);
    found      = 1'b0;
    for (int k = 1; k <= N_DIR; k++) begin
      idx = (int'(cur) + k) % N_DIR;
      if (!found && rq[idx]) begin
        f_next_req = AW'(idx);
        found      = 1'b1;
      end
    end
  endfunction

  traffic_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  assign w_expire = w_tick && (r_timer == TW'(1));
  assign w_other  = |(i_req & ~(N_DIR'(1) << r_active));

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_active_nxt = r_active;
    w_phase_nxt  = r_phase;
    w_restart    = 1'b0;
    if (i_flash) begin
      if (r_state != FLASH) begin
        w_state_nxt = FLASH;
        w_phase_nxt = 1'b1;
        w_restart   = 1'b1;
      end else if (w_tick) begin
        w_phase_nxt = ~r_phase;
      end
    end else begin
      case (r_state)
        FLASH: begin
          w_state_nxt = ALL_RED;
          w_timer_nxt = TW'(ALLRED_T);
          w_restart   = 1'b1;
        end
        ALL_RED: begin
          if (w_expire) begin
            w_state_nxt  = GREEN;
            w_active_nxt = f_next_req(r_active, i_req);
            w_timer_nxt  = TW'(GREEN_T);
            w_restart    = 1'b1;
          end else if (w_tick) begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        GREEN: begin
          if (w_expire) begin
            w_restart = 1'b1;
            if (w_other) begin
              w_state_nxt = YELLOW;
              w_timer_nxt = TW'(YELLOW_T);
            end else begin
              w_timer_nxt = TW'(GREEN_T);
            end
          end else if (w_tick) begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        default: begin
          if (w_expire) begin
            w_state_nxt = ALL_RED;
            w_timer_nxt = TW'(ALLRED_T);
            w_restart   = 1'b1;
          end else if (w_tick) begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
      endcase
    end
  end

  // Decode lamps from next-state values so they switch on the state edge.
  always_comb begin
    w_lamp    = '0;
    w_lamp[R] = '1;
    case (w_state_nxt)
      GREEN: begin
        w_lamp[G][w_active_nxt] = 1'b1;
        w_lamp[R][w_active_nxt] = 1'b0;
      end
      YELLOW: begin
        w_lamp[Y][w_active_nxt] = 1'b1;
        w_lamp[R][w_active_nxt] = 1'b0;
      end
      FLASH: begin
        w_lamp[R] = '0;
        w_lamp[Y] = {N_DIR{w_phase_nxt}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ALL_RED;
      r_timer  <= TW'(ALLRED_T);
      r_active <= AW'(N_DIR - 1);
      r_phase  <= 1'b0;
      r_green  <= '0;
      r_yellow <= '0;
      r_red    <= '1;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_active <= w_active_nxt;
      r_phase  <= w_phase_nxt;
      r_green  <= w_lamp[G];
      r_yellow <= w_lamp[Y];
      r_red    <= w_lamp[R];
    end
  end

  assign o_green  = r_green;
  assign o_yellow = r_yellow;
  assign o_red    = r_red;
  assign o_active = r_active;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Self-checking bench for traffic_ctrl: cycle-count reference model plus
// directed literal checks and a randomized soak.
module tb_traffic_ctrl;

  localparam int N   = 3;
  localparam int DIV = 4;
  localparam int GT  = 3;
  localparam int YT  = 2;
  localparam int AT  = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         flash = 1'b0;
  logic [N-1:0] green, yellow, red;
  logic [1:0]   active;

  int n_chk  = 0;
  int n_fail = 0;

  traffic_ctrl #(
    .N_DIR(N), .TICK_DIV(DIV), .GREEN_T(GT), .YELLOW_T(YT), .ALLRED_T(AT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_flash(flash),
    .o_green(green), .o_yellow(yellow), .o_red(red), .o_active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode 0=all-red 1=green 2=yellow 3=flash, with the
  // remaining time of the current state counted directly in clk cycles.
  int m_mode, m_left, m_act, m_fcyc;
  bit m_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_left = AT * DIV; m_act = N - 1; m_fcyc = 0; m_valid = 1;
    end else if (m_valid) begin
      if (flash) begin
        if (m_mode != 3) begin m_mode = 3; m_fcyc = 0; end
        else m_fcyc++;
      end else if (m_mode == 3) begin
        m_mode = 0; m_left = AT * DIV;
      end else begin
        m_left--;
        if (m_left == 0) begin
          case (m_mode)
            0: begin
              int pick;
              pick = (m_act + 1) % N;
              for (int k = N; k >= 1; k--)
                if (req[(m_act + k) % N]) pick = (m_act + k) % N;
              m_act = pick; m_mode = 1; m_left = GT * DIV;
            end
            1: begin
              bit other;
              other = 0;
              for (int i = 0; i < N; i++) if (i != m_act && req[i]) other = 1;
              if (other) begin m_mode = 2; m_left = YT * DIV; end
              else m_left = GT * DIV;
            end
            default: begin m_mode = 0; m_left = AT * DIV; end
          endcase
        end
      end
    end
    #1;
    if (m_valid) begin
      logic [N-1:0] eg, ey, er;
      eg = '0; ey = '0; er = '1;
      case (m_mode)
        1: begin eg[m_act] = 1'b1; er[m_act] = 1'b0; end
        2: begin ey[m_act] = 1'b1; er[m_act] = 1'b0; end
        3: begin er = '0; ey = (((m_fcyc / DIV) % 2) == 0) ? '1 : '0; end
        default: ;
      endcase
      chk("model_green",  32'(green),  32'(eg));
      chk("model_yellow", 32'(yellow), 32'(ey));
      chk("model_red",    32'(red),    32'(er));
      chk("model_active", 32'(active), 32'(m_act));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int fhold;
    cyc(2);
    // 1: reset with no requests
    rst = 1'b0;
    chk("s1_red_rst", 32'(red), 32'b111);
    chk("s1_green_rst", 32'(green), 32'b000);
    chk("s1_yellow_rst", 32'(yellow), 32'b000);
    chk("s1_active_rst", 32'(active), 32'd2);
    cyc(4);
    chk("s1_green", 32'(green), 32'b001);
    chk("s1_red", 32'(red), 32'b110);
    chk("s1_active", 32'(active), 32'd0);
    // 2: skip approach 1
    req = 3'b100;
    cyc(11); chk("s2_green_hold", 32'(green), 32'b001);
    cyc(1);  chk("s2_yellow", 32'(yellow), 32'b001);
    cyc(7);  chk("s2_yellow_hold", 32'(yellow), 32'b001);
    cyc(1);  chk("s2_allred", 32'(red), 32'b111);
    cyc(3);  chk("s2_allred_hold", 32'(red), 32'b111);
    cyc(1);  chk("s2_green2", 32'(green), 32'b100);
    chk("s2_active2", 32'(active), 32'd2);
    // 3: rest on green
    req = 3'b000;
    cyc(30); chk("s3_rest", 32'(green), 32'b100);
    // 4: wrap-around from 2 to 0 with req=011
    req = 3'b011;
    for (int k = 0; k < 20 && yellow == 0; k++) cyc(1);
    chk("s4_yellow2", 32'(yellow), 32'b100);
    for (int k = 0; k < 20 && green == 0; k++) cyc(1);
    chk("s4_green0", 32'(green), 32'b001);
    chk("s4_active0", 32'(active), 32'd0);
    // 5: flash mid-green
    cyc(2);
    flash = 1'b1;
    cyc(1);
    chk("s5_fl_green", 32'(green), 32'b000);
    chk("s5_fl_red", 32'(red), 32'b000);
    chk("s5_fl_yellow", 32'(yellow), 32'b111);
    cyc(4); chk("s5_fl_off", 32'(yellow), 32'b000);
    cyc(4); chk("s5_fl_on", 32'(yellow), 32'b111);
    flash = 1'b0;
    cyc(1); chk("s5_exit_red", 32'(red), 32'b111);
    cyc(3); chk("s5_exit_red_hold", 32'(red), 32'b111);
    cyc(1); chk("s5_green1", 32'(green), 32'b010);
    chk("s5_active1", 32'(active), 32'd1);
    // 6: reset mid-yellow, then scenario 1 again
    for (int k = 0; k < 20 && yellow == 0; k++) cyc(1);
    chk("s6_in_yellow", 32'(yellow), 32'b010);
    cyc(1);
    rst = 1'b1; req = 3'b000;
    cyc(1);
    rst = 1'b0;
    chk("s6_red_rst", 32'(red), 32'b111);
    chk("s6_yellow_rst", 32'(yellow), 32'b000);
    chk("s6_active_rst", 32'(active), 32'd2);
    cyc(4);
    chk("s6_green", 32'(green), 32'b001);
    chk("s6_active", 32'(active), 32'd0);
    // randomized soak against the model
    fhold = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 11) == 0) req = N'($urandom_range(0, 7));
      if (fhold > 0) begin
        fhold--;
        if (fhold == 0) flash = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        flash = 1'b1; fhold = $urandom_range(1, 30);
      end
    end
    rst = 1'b0; flash = 1'b0;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
